// File: rtl/cpu_run_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctl
// Purpose  : Run / halt / single-step sequencer for the 5-stage stack
//            pipeline. Sits beside cpu_fetch and gates instruction issue.
//            It stops on a PC breakpoint, and it drains in-flight work before
//            it reports halted. It also counts accepted issues.
// Options  : CPU_RUN_CTL_CYCLE_LIMIT_EN - when defined, a per-RUN cycle
//            budget (cyc_limit_i) is built. The budget forces DRAIN and sets
//            the sticky limit_hit_o flag.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            run_req_i        - level, leave HALTED and free-run
//            step_req_i       - pulse, issue exactly one instruction
//            halt_req_i       - pulse, stop issuing while in RUN
//            bp_en_i          - breakpoint enable
//            bp_addr_i        - breakpoint PC
//            pc_1a_i          - PC presented by fetch this cycle
//            stall_2a_i       - decode stall, fetch not accepted
//            kill_4a_i        - branch kill from memory stage
//            cyc_limit_i      - RUN cycle budget (0 = unlimited, option only)
//            fetch_en_o       - fetch may issue pc_1a_i this cycle
//            halted_o         - pipeline idle in HALTED
//            state_o          - 0 HALTED, 1 RUN, 2 STEP, 3 DRAIN
//            issue_cnt_o      - accepted issues since reset (wraps)
//            limit_hit_o      - sticky, RUN ended by cycle budget
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctl #(
  parameter int PC_W      = 32,
  parameter int DRAIN_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_req_i,
  input  logic            step_req_i,
  input  logic            halt_req_i,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_1a_i,
  input  logic            stall_2a_i,
  input  logic            kill_4a_i,
  input  logic [31:0]     cyc_limit_i,
  output logic            fetch_en_o,
  output logic            halted_o,
  output logic [1:0]      state_o,
  output logic [31:0]     issue_cnt_o,
  output logic            limit_hit_o
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int             CNT_W      = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC);

  if (DRAIN_CYC < 1) begin : g_bad_drain_cyc
    $error("cpu_run_ctl: DRAIN_CYC must be at least 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               bp_skip_q, bp_skip_d;
  logic [31:0]        issue_cnt_q, issue_cnt_d;
  logic               halted_q, halted_d;

  logic               bp_hit;
  logic               fetch_en;
  logic               issue;
  logic               budget_hit;

  // fetch_en must be combinational on pc_1a_i. A breakpoint has to block
  // the very instruction that matches, not the one after it. STEP leaves on
  // the edge that accepts its issue, so fetch_en is held high for the whole
  // of STEP, including stalled cycles.
  assign bp_hit   = bp_en_i & ~bp_skip_q & (pc_1a_i == bp_addr_i) & (state_q == ST_RUN);
  assign fetch_en = ((state_q == ST_RUN) & ~bp_hit) | (state_q == ST_STEP);
  assign issue    = fetch_en & ~stall_2a_i;

  // --------------------------------------------------------------------------
  // Optional run-cycle budget
  // --------------------------------------------------------------------------
`ifdef CPU_RUN_CTL_CYCLE_LIMIT_EN
  logic [31:0] run_cyc_q, run_cyc_d;
  logic        limit_hit_q, limit_hit_d;

  // run_cyc_q counts completed RUN cycles. The budget fires in the cycle
  // that would complete the cyc_limit_i-th RUN cycle.
  assign budget_hit = (state_q == ST_RUN) && (cyc_limit_i != 32'd0) &&
                      ((run_cyc_q + 32'd1) == cyc_limit_i);

  always_comb begin
    run_cyc_d   = run_cyc_q;
    limit_hit_d = limit_hit_q | budget_hit;
    if ((state_q == ST_HALTED) && run_req_i) begin
      run_cyc_d = 32'd0;
    end else if (state_q == ST_RUN) begin
      run_cyc_d = run_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cyc_q   <= 32'd0;
      limit_hit_q <= 1'b0;
    end else begin
      run_cyc_q   <= run_cyc_d;
      limit_hit_q <= limit_hit_d;
    end
  end

  assign limit_hit_o = limit_hit_q;
`else
  logic unused_cyc_limit;
  assign unused_cyc_limit = ^cyc_limit_i;
  assign budget_hit       = 1'b0;
  assign limit_hit_o      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    bp_skip_d   = bp_skip_q;
    issue_cnt_d = issue_cnt_q + {31'd0, issue};

    // The skip covers only the first instruction accepted after resuming.
    if (issue) begin
      bp_skip_d = 1'b0;
    end

    case (state_q)
      ST_HALTED: begin
        // Resuming at bp_addr must not re-hit immediately, so arm the skip.
        if (run_req_i) begin
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end else if (step_req_i) begin
          state_d   = ST_STEP;
          bp_skip_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req_i || bp_hit || budget_hit) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_STEP: begin
        if (issue) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A kill redirects fetch. The redirected work counts as in flight,
        // so the quiet window restarts.
        if (kill_4a_i) begin
          drain_d = DRAIN_LOAD;
        end else if (drain_q == CNT_W'(1)) begin
          state_d = ST_HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALTED;
      drain_q     <= '0;
      bp_skip_q   <= 1'b0;
      issue_cnt_q <= 32'd0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      bp_skip_q   <= bp_skip_d;
      issue_cnt_q <= issue_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign fetch_en_o  = fetch_en;
  assign halted_o    = halted_q;
  assign state_o     = state_q;
  assign issue_cnt_o = issue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctl
// Purpose  : Self-checking bench for cpu_run_ctl. It runs a directed vector
//            table, hand-written reset/limit sequences and randomized
//            stimulus. All of these are checked against a cycle-level
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctl;

  localparam int PC_W      = 32;
  localparam int DRAIN_CYC = 4;
`ifdef CPU_RUN_CTL_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            run_req, step_req, halt_req, bp_en;
  logic [PC_W-1:0] bp_addr, pc_1a;
  logic            stall, kill;
  logic [31:0]     cyc_limit;
  logic            fetch_en, halted, limit_hit;
  logic [1:0]      state;
  logic [31:0]     issue_cnt;

  int total = 0;
  int bad   = 0;

  cpu_run_ctl #(.PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_req_i   (run_req),
    .step_req_i  (step_req),
    .halt_req_i  (halt_req),
    .bp_en_i     (bp_en),
    .bp_addr_i   (bp_addr),
    .pc_1a_i     (pc_1a),
    .stall_2a_i  (stall),
    .kill_4a_i   (kill),
    .cyc_limit_i (cyc_limit),
    .fetch_en_o  (fetch_en),
    .halted_o    (halted),
    .state_o     (state),
    .issue_cnt_o (issue_cnt),
    .limit_hit_o (limit_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 halted, 1 run, 2 step, 3 drain.
  int          m_mode;
  int          m_quiet;    // consecutive kill-free drain cycles
  bit          m_skip;
  int unsigned m_cnt;
  bit          m_lim;
  int unsigned m_runcyc;

  task automatic m_reset();
    m_mode = 0; m_quiet = 0; m_skip = 0; m_cnt = 0; m_lim = 0; m_runcyc = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    run_req = 0; step_req = 0; halt_req = 0; stall = 0; kill = 0;
  endtask

  // One clock cycle. fetch_en is checked at the negedge. The model is then
  // advanced, and the registered outputs are checked 1 unit after posedge.
  task automatic tick(output bit fe_seen);
    bit bp, fe, iss, bud;
    bud = 1'b0;
    @(negedge clk);
    bp = bp_en && !m_skip && (pc_1a == bp_addr) && (m_mode == 1);
    fe = ((m_mode == 1) && !bp) || (m_mode == 2);
    fe_seen = fetch_en;
    chk("fetch_en", {63'd0, fetch_en}, {63'd0, fe});
    iss = fe && !stall;
    if (iss) begin
      m_cnt++;
      m_skip = 1'b0;
    end
    case (m_mode)
      0: begin
        if (run_req) begin
          m_mode = 1; m_skip = 1'b1; m_runcyc = 0;
        end else if (step_req) begin
          m_mode = 2; m_skip = 1'b1;
        end
      end
      1: begin
        m_runcyc++;
        bud = LIMIT_EN && (cyc_limit != 0) && (m_runcyc == cyc_limit);
        if (bud) m_lim = 1'b1;
        if (halt_req || bp || bud) begin
          m_mode = 3; m_quiet = 0;
        end
      end
      2: begin
        if (iss) begin
          m_mode = 3; m_quiet = 0;
        end
      end
      default: begin
        if (kill) m_quiet = 0;
        else      m_quiet++;
        if (m_quiet == DRAIN_CYC) m_mode = 0;
      end
    endcase
    @(posedge clk);
    #1;
    chk("state",     {62'd0, state},     64'(m_mode));
    chk("halted",    {63'd0, halted},    {63'd0, (m_mode == 0)});
    chk("issue_cnt", {32'd0, issue_cnt}, {32'd0, m_cnt});
    chk("limit_hit", {63'd0, limit_hit}, {63'd0, m_lim});
  endtask

  task automatic ticks(input int n);
    bit d;
    for (int i = 0; i < n; i++) tick(d);
  endtask

  // Asynchronous reset issued mid-cycle, away from both clock edges.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    m_reset();
    chk("rst_state",  {62'd0, state},     64'd0);
    chk("rst_halted", {63'd0, halted},    64'd1);
    chk("rst_fetch",  {63'd0, fetch_en},  64'd0);
    chk("rst_cnt",    {32'd0, issue_cnt}, 64'd0);
    chk("rst_limit",  {63'd0, limit_hit}, 64'd0);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int          n;
    bit          run, step, halt, bpen;
    logic [31:0] pc;
    bit          stall, kill;
    bit          efe;
    logic [1:0]  est;
    bit          ehalt;
    int unsigned ecnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int n, bit run, bit step, bit halt, bit bpen,
                              logic [31:0] pc, bit stl, bit kil,
                              bit efe, logic [1:0] est, bit ehalt, int unsigned ecnt);
    vec_t v;
    v.n = n; v.run = run; v.step = step; v.halt = halt; v.bpen = bpen;
    v.pc = pc; v.stall = stl; v.kill = kil;
    v.efe = efe; v.est = est; v.ehalt = ehalt; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    bit fe_last;
    rst = 1'b1;
    idle_inputs();
    bp_en = 0; bp_addr = 32'h40; pc_1a = 32'h0; cyc_limit = 32'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_state",  {62'd0, state},     64'd0);
    chk("por_halted", {63'd0, halted},    64'd1);
    chk("por_fetch",  {63'd0, fetch_en},  64'd0);
    chk("por_cnt",    {32'd0, issue_cnt}, 64'd0);
    rst = 1'b0;

    //                n run stp hlt bpe pc     stl kil  efe st hlt cnt
    vq.push_back(mk(1, 1, 0, 0, 0, 32'h00, 0, 0,  0, 1, 0, 0));  // HALTED -> RUN
    vq.push_back(mk(9, 0, 0, 0, 0, 32'h00, 0, 0,  1, 1, 0, 9));
    vq.push_back(mk(1, 0, 0, 1, 0, 32'h00, 0, 0,  1, 3, 0, 10)); // 10th issue on halt edge
    vq.push_back(mk(3, 0, 0, 0, 0, 32'h00, 0, 0,  0, 3, 0, 10));
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h00, 0, 0,  0, 0, 1, 10)); // DRAIN_CYC after entry
    vq.push_back(mk(1, 0, 1, 0, 0, 32'h00, 0, 0,  0, 2, 0, 10)); // step
    vq.push_back(mk(3, 0, 0, 0, 0, 32'h00, 1, 0,  1, 2, 0, 10)); // stalled step holds
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h00, 0, 0,  1, 3, 0, 11));
    vq.push_back(mk(4, 0, 0, 0, 0, 32'h00, 0, 0,  0, 0, 1, 11));
    vq.push_back(mk(1, 1, 0, 0, 1, 32'h3C, 0, 0,  0, 1, 0, 11)); // bp armed run
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h3C, 0, 0,  1, 1, 0, 12));
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h40, 0, 0,  0, 3, 0, 12)); // bp hit, bubble
    vq.push_back(mk(4, 0, 0, 0, 1, 32'h40, 0, 0,  0, 0, 1, 12));
    vq.push_back(mk(1, 1, 0, 0, 1, 32'h40, 0, 0,  0, 1, 0, 12)); // resume at bp
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h40, 1, 0,  1, 1, 0, 12)); // skip survives stall
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h40, 0, 0,  1, 1, 0, 13)); // 0x40 issues once
    vq.push_back(mk(2, 0, 0, 0, 1, 32'h44, 0, 0,  1, 1, 0, 15));
    vq.push_back(mk(1, 0, 0, 1, 1, 32'h40, 0, 0,  0, 3, 0, 15)); // halt + bp same cycle
    vq.push_back(mk(3, 0, 0, 0, 1, 32'h40, 0, 0,  0, 3, 0, 15)); // drain cnt now 1
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h40, 0, 1,  0, 3, 0, 15)); // kill at cnt 1
    vq.push_back(mk(3, 0, 0, 0, 1, 32'h40, 0, 0,  0, 3, 0, 15));
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h40, 0, 0,  0, 0, 1, 15));

    foreach (vq[r]) begin
      for (int k = 0; k < vq[r].n; k++) begin
        run_req = vq[r].run; step_req = vq[r].step; halt_req = vq[r].halt;
        bp_en = vq[r].bpen; pc_1a = vq[r].pc; stall = vq[r].stall; kill = vq[r].kill;
        tick(fe_last);
      end
      chk("vec_fetch",  {63'd0, fe_last},   {63'd0, vq[r].efe});
      chk("vec_state",  {62'd0, state},     {62'd0, vq[r].est});
      chk("vec_halted", {63'd0, halted},    {63'd0, vq[r].ehalt});
      chk("vec_cnt",    {32'd0, issue_cnt}, {32'd0, vq[r].ecnt});
    end
    idle_inputs();
    bp_en = 0;

    // Reset in the middle of RUN.
    run_req = 1; tick(fe_last);
    run_req = 0; ticks(3);
    do_reset();
    ticks(2);

`ifdef CPU_RUN_CTL_CYCLE_LIMIT_EN
    // Budget of 5 RUN cycles, then a rerun with no budget keeps the flag.
    do_reset();
    cyc_limit = 32'd5;
    run_req = 1; tick(fe_last);
    run_req = 0; ticks(4);
    chk("lim_run4",   {62'd0, state},     64'd1);
    chk("lim_flag4",  {63'd0, limit_hit}, 64'd0);
    ticks(1);
    chk("lim_drain",  {62'd0, state},     64'd3);
    chk("lim_flag",   {63'd0, limit_hit}, 64'd1);
    chk("lim_cnt",    {32'd0, issue_cnt}, 64'd5);
    cyc_limit = 32'd0;
    ticks(DRAIN_CYC);
    run_req = 1; tick(fe_last);
    run_req = 0; ticks(10);
    chk("lim_rerun",  {62'd0, state},     64'd1);
    chk("lim_sticky", {63'd0, limit_hit}, 64'd1);
    halt_req = 1; tick(fe_last);
    halt_req = 0; ticks(DRAIN_CYC);
`endif

    // Randomized stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      run_req  = ($urandom_range(0, 7) == 0);
      step_req = ($urandom_range(0, 5) == 0);
      halt_req = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 2) == 0);
      kill     = ($urandom_range(0, 7) == 0);
      if (c % 250 == 0) begin
        bp_en     = $urandom_range(0, 1);
        bp_addr   = 32'h40 + 32'($urandom_range(0, 2)) * 32'd4;
        cyc_limit = 32'($urandom_range(0, 12));
      end
      case ($urandom_range(0, 3))
        0:       pc_1a = 32'h40;
        1:       pc_1a = 32'h44;
        2:       pc_1a = 32'h48;
        default: pc_1a = $urandom;
      endcase
      tick(fe_last);
      if (c == 2000) begin
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
